// File: rtl/lagrange_interp_sched.sv
// ============================================================================
// Module   : lagrange_interp_sched
// Brief    : Round-robin scheduler sharing one Lagrange interpolation engine
//            among several requesters; latches a job, launches, collects.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef F_NBITS
`define F_NBITS 32
`endif

module lagrange_interp_sched #(
   parameter int npoints = 3,
   parameter int nreq    = 4
) (
   input  logic                clk,
   input  logic                rstb,
   input  logic [nreq-1:0]     req,
   input  logic [`F_NBITS-1:0] yi_in [nreq-1:0][npoints-1:0],
   output logic [nreq-1:0]     grant,
   output logic [nreq-1:0]     done,
   output logic [`F_NBITS-1:0] coeff_out [npoints-1:0],
   output logic                busy,
   output logic                err,
   output logic                interp_en,
   output logic [`F_NBITS-1:0] interp_yi [npoints-1:0],
   input  logic                interp_ready,
   input  logic                interp_c_wren,
   input  logic [`F_NBITS-1:0] interp_c_data
);

   localparam int c_PTR_W = (nreq > 1) ? $clog2(nreq) : 1;
   localparam int c_CNT_W = $clog2(npoints + 1);
   localparam logic [c_CNT_W-1:0] c_NPTS = c_CNT_W'(npoints);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LAUNCH  = 2'd1,
      ST_COLLECT = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_PTR_W-1:0]   r_ptr;
   logic [c_PTR_W-1:0]   r_win;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 r_ready_q;

   logic                 w_found;
   logic [c_PTR_W-1:0]   w_win;
   int                   w_idx;
   logic                 w_grant_ld;
   logic                 w_launch;
   logic                 w_capture;
   logic                 w_err_set;
   logic                 w_enter_done;

   // First requester at or after the pointer, wrapping around.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = 0;
      for (int i = 0; i < nreq; i++) begin
         w_idx = int'(r_ptr) + i;
         if (w_idx >= nreq) begin
            w_idx = w_idx - nreq;
         end
         for (int j = 0; j < nreq; j++) begin
            if (!w_found && (j == w_idx) && req[j]) begin
               w_found = 1'b1;
               w_win   = c_PTR_W'(j);
            end
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_ld   = 1'b0;
      w_launch     = 1'b0;
      w_enter_done = 1'b0;
      w_capture    = (r_state == ST_COLLECT) && interp_c_wren && (r_cnt != c_NPTS);
      w_err_set    = interp_c_wren && !w_capture;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt = ST_LAUNCH;
               w_grant_ld  = 1'b1;
            end
         end
         ST_LAUNCH: begin
            if (interp_ready) begin
               w_state_nxt = ST_COLLECT;
               w_launch    = 1'b1;
            end
         end
         ST_COLLECT: begin
            if ((r_cnt == c_NPTS) && interp_ready) begin
               w_state_nxt  = ST_DONE;
               w_enter_done = 1'b1;
            end else if ((r_cnt != c_NPTS) && interp_ready && !r_ready_q) begin
               // Engine went idle before delivering every coefficient.
               w_state_nxt  = ST_DONE;
               w_enter_done = 1'b1;
               w_err_set    = 1'b1;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_win     <= '0;
         r_cnt     <= '0;
         r_ready_q <= 1'b0;
         grant     <= '0;
         done      <= '0;
         busy      <= 1'b0;
         err       <= 1'b0;
         interp_en <= 1'b0;
         for (int k = 0; k < npoints; k++) begin
            coeff_out[k] <= '0;
            interp_yi[k] <= '0;
         end
      end else begin
         r_state   <= w_state_nxt;
         r_ready_q <= interp_ready;
         busy      <= (w_state_nxt != ST_IDLE);
         interp_en <= w_launch;
         done      <= '0;
         if (w_err_set) begin
            err <= 1'b1;
         end
         if (w_grant_ld) begin
            r_win <= w_win;
            r_cnt <= '0;
            for (int i = 0; i < nreq; i++) begin
               grant[i] <= (w_win == c_PTR_W'(i));
               if (w_win == c_PTR_W'(i)) begin
                  interp_yi <= yi_in[i];
               end
            end
         end
         if (w_capture) begin
            for (int k = 0; k < npoints; k++) begin
               if (r_cnt == c_CNT_W'(k)) begin
                  coeff_out[k] <= interp_c_data;
               end
            end
            r_cnt <= r_cnt + c_CNT_W'(1);
         end
         if (w_enter_done) begin
            done <= grant;
         end
         if (r_state == ST_DONE) begin
            grant <= '0;
            r_ptr <= (r_win == c_PTR_W'(nreq - 1)) ? '0 : r_win + c_PTR_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lagrange_interp_sched.sv
// ============================================================================
// Module   : tb_lagrange_interp_sched
// Brief    : Scoreboard bench with an engine model and round-robin reference.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef F_NBITS
`define F_NBITS 32
`endif

module tb_lagrange_interp_sched;

   localparam int NREQ = 4;
   localparam int NPTS = 3;
   localparam int FW   = `F_NBITS;

   typedef logic [FW-1:0] word_t;
   typedef struct {
      logic [NREQ-1:0] oh;
      word_t           yi [NPTS];
      word_t           co [NPTS];
      logic            er;
   } exp_t;
   typedef struct {
      word_t w [4];
      int    n;
      int    hold;
   } prog_t;

   logic            clk;
   logic            rstb;
   logic [NREQ-1:0] req;
   word_t           yi_in [NREQ-1:0][NPTS-1:0];
   logic [NREQ-1:0] grant;
   logic [NREQ-1:0] done;
   word_t           coeff_out [NPTS-1:0];
   logic            busy;
   logic            err;
   logic            interp_en;
   word_t           interp_yi [NPTS-1:0];
   logic            interp_ready;
   logic            interp_c_wren;
   word_t           interp_c_data;

   lagrange_interp_sched #(.npoints(NPTS), .nreq(NREQ)) dut (
      .clk           (clk),
      .rstb          (rstb),
      .req           (req),
      .yi_in         (yi_in),
      .grant         (grant),
      .done          (done),
      .coeff_out     (coeff_out),
      .busy          (busy),
      .err           (err),
      .interp_en     (interp_en),
      .interp_yi     (interp_yi),
      .interp_ready  (interp_ready),
      .interp_c_wren (interp_c_wren),
      .interp_c_data (interp_c_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   exp_t  sb [256];
   int    sb_wr;
   int    sb_rd;
   prog_t prog [256];
   int    p_wr;
   int    e_rd;
   int    e_phase;
   int    e_widx;
   int    m_ptr;
   logic  m_err;
   word_t m_co [NPTS];
   int    n_vec;
   int    n_err;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
      end
   endtask

   // Engine model: optional pre-start busy time, then streams its words one per cycle.
   initial begin
      prog_t cur;
      int    hold;
      bit    pg;
      interp_ready  = 1'b1;
      interp_c_wren = 1'b0;
      interp_c_data = '0;
      e_rd = 0; e_phase = 0; e_widx = 0; hold = 0; pg = 1'b0;
      cur = prog[0];
      forever begin
         @(posedge clk); #1;
         if (!rstb) begin
            interp_ready = 1'b1; interp_c_wren = 1'b0; interp_c_data = '0;
            e_phase = 0; hold = 0; pg = 1'b0;
         end else begin
            if ((grant != '0) && !pg && (e_rd < p_wr)) hold = prog[e_rd].hold;
            pg = (grant != '0);
            if (e_phase == 0) begin
               interp_c_wren = 1'b0;
               if (hold > 0) begin
                  interp_ready = 1'b0;
                  hold--;
               end else begin
                  interp_ready = 1'b1;
               end
               if (interp_en) begin
                  cur = prog[e_rd]; e_rd++; e_widx = 0; e_phase = 1;
               end
            end else if (e_widx < cur.n) begin
               interp_ready  = 1'b0;
               interp_c_wren = 1'b1;
               interp_c_data = cur.w[e_widx];
               e_widx++;
            end else begin
               interp_ready = 1'b1; interp_c_wren = 1'b0; e_phase = 0;
            end
         end
      end
   end

   // Monitor: reset values, start-pulse protocol, and scoreboard pops on done.
   initial begin
      int   en_cnt, wd;
      bit   post, rst_seen;
      logic prev_en, prev_rdy;
      exp_t e;
      n_vec = 0; n_err = 0; sb_rd = 0;
      en_cnt = 0; wd = 0; post = 1'b0; rst_seen = 1'b0; prev_en = 1'b0; prev_rdy = 1'b1;
      forever begin
         @(negedge clk);
         if (!rstb) begin
            if (!rst_seen) begin
               chk("rst_grant", 64'(grant), 64'd0);
               chk("rst_done", 64'(done), 64'd0);
               chk("rst_busy", 64'(busy), 64'd0);
               chk("rst_err", 64'(err), 64'd0);
               chk("rst_interp_en", 64'(interp_en), 64'd0);
               for (int k = 0; k < NPTS; k++) begin
                  chk("rst_coeff_out", 64'(coeff_out[k]), 64'd0);
                  chk("rst_interp_yi", 64'(interp_yi[k]), 64'd0);
               end
            end
            rst_seen = 1'b1; en_cnt = 0; post = 1'b0; prev_en = 1'b0; prev_rdy = 1'b1; wd = 0;
         end else begin
            rst_seen = 1'b0;
            if (interp_en) begin
               chk("en_back_to_back", 64'(prev_en), 64'd0);
               chk("en_without_ready", 64'(prev_rdy), 64'd1);
               en_cnt++;
            end
            if (done != '0) begin
               if (sb_rd == sb_wr) begin
                  chk("unexpected_done", 64'(done), 64'd0);
               end else begin
                  e = sb[sb_rd];
                  sb_rd++;
                  chk("done", 64'(done), 64'(e.oh));
                  chk("grant_at_done", 64'(grant), 64'(e.oh));
                  chk("err", 64'(err), 64'(e.er));
                  chk("busy_at_done", 64'(busy), 64'd1);
                  chk("en_pulses_per_job", 64'(en_cnt), 64'd1);
                  for (int k = 0; k < NPTS; k++) begin
                     chk("coeff_out", 64'(coeff_out[k]), 64'(e.co[k]));
                     chk("interp_yi", 64'(interp_yi[k]), 64'(e.yi[k]));
                  end
               end
               en_cnt = 0; post = 1'b1; wd = 0;
            end else if (post) begin
               chk("grant_after_done", 64'(grant), 64'd0);
               chk("busy_after_done", 64'(busy), 64'd0);
               post = 1'b0;
            end
            if (sb_rd != sb_wr) begin
               wd++;
               if (wd > 300) begin
                  n_vec++; n_err++;
                  $display("FAIL job_timeout: no done after %0d cycles, expected done=%b", wd, sb[sb_rd].oh);
                  sb_rd++; wd = 0;
               end
            end else begin
               wd = 0;
            end
            prev_en  = interp_en;
            prev_rdy = interp_ready;
         end
      end
   end

   // Reference: winner = first requesting index scanning upward from the pointer.
   task automatic issue(input word_t w0, input word_t w1, input word_t w2, input word_t w3,
                        input int nw, input int hold, input bit track);
      prog_t           p;
      exp_t            e;
      int              win;
      logic [NREQ-1:0] rq;
      p.w[0] = w0; p.w[1] = w1; p.w[2] = w2; p.w[3] = w3; p.n = nw; p.hold = hold;
      prog[p_wr] = p;
      p_wr++;
      if (track) begin
         rq  = req;
         win = -1;
         for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = (m_ptr + i) % NREQ;
            if ((win < 0) && (((rq >> idx) & 1) != 0)) win = idx;
         end
         m_ptr = (win + 1) % NREQ;
         for (int k = 0; k < NPTS; k++) begin
            if (k < nw) m_co[k] = p.w[k];
            e.co[k] = m_co[k];
            e.yi[k] = yi_in[win][k];
         end
         if (nw != NPTS) m_err = 1'b1;
         e.er = m_err;
         e.oh = NREQ'(1) << win;
         sb[sb_wr] = e;
         sb_wr++;
      end
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 2000 && !ok; c++) begin
         @(negedge clk);
         if (sb_rd == sb_wr) ok = 1'b1;
      end
      if (!ok) begin
         $display("FAIL drain_timeout: pending jobs %0d, expected 0", sb_wr - sb_rd);
         $fatal(1, "scheduler stalled");
      end
   endtask

   task automatic rand_yi();
      for (int r = 0; r < NREQ; r++)
         for (int k = 0; k < NPTS; k++)
            yi_in[r][k] = word_t'($urandom);
   endtask

   task automatic rand_job(input int nw, input int hold);
      issue(word_t'($urandom), word_t'($urandom), word_t'($urandom), word_t'($urandom), nw, hold, 1'b1);
   endtask

   initial begin
      bit ok;
      rstb = 1'b0; req = '0; sb_wr = 0; p_wr = 0; m_ptr = 0; m_err = 1'b0;
      for (int k = 0; k < NPTS; k++) m_co[k] = '0;
      rand_yi();
      repeat (3) @(negedge clk);
      rstb = 1'b1;
      @(negedge clk);

      // Single job with known values.
      yi_in[0][0] = 5; yi_in[0][1] = 7; yi_in[0][2] = 9;
      req = 4'b0001;
      issue(5, 11, 3, 0, 3, 0, 1'b1);
      drain();

      // Round robin with held requests, then a new pattern.
      req = 4'b0101;
      repeat (3) rand_job(3, 0);
      drain();
      req = 4'b0011;
      repeat (2) rand_job(3, 0);
      drain();

      // Engine busy for 10 cycles after the grant.
      req = 4'b0100;
      rand_job(3, 10);
      drain();

      // Inputs change after the grant.
      req = 4'b0001;
      rand_job(3, 3);
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         if (grant != '0) ok = 1'b1;
      end
      if (!ok) begin
         $display("FAIL grant_timeout: grant=%b, expected nonzero", grant);
         $fatal(1, "no grant");
      end
      for (int k = 0; k < NPTS; k++) yi_in[0][k] = word_t'($urandom);
      req = 4'b0000;
      drain();

      // Random well-formed jobs.
      for (int j = 0; j < 20; j++) begin
         rand_yi();
         req = NREQ'($urandom_range(1, 15));
         rand_job(3, $urandom_range(0, 4));
         drain();
      end
      req = '0;

      // Protocol errors: one extra word, then a short job.
      req = 4'b0010;
      rand_job(4, 0);
      drain();
      req = 4'b0100;
      rand_job(2, 0);
      drain();

      // Reset during collection; the job vanishes and the pointer restarts at 0.
      req = 4'b1000;
      issue(word_t'($urandom), word_t'($urandom), word_t'($urandom), 0, 3, 0, 1'b0);
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clk);
         if ((e_phase == 1) && (e_widx >= 3)) ok = 1'b1;
      end
      if (!ok) begin
         $display("FAIL collect_timeout: engine words %0d, expected 3", e_widx);
         $fatal(1, "engine never started");
      end
      rstb = 1'b0; req = '0; m_ptr = 0; m_err = 1'b0;
      for (int k = 0; k < NPTS; k++) m_co[k] = '0;
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      @(negedge clk);
      req = 4'b1111;
      rand_job(3, 0);
      drain();

      // Random jobs mixing in malformed word counts.
      for (int j = 0; j < 10; j++) begin
         int sel;
         rand_yi();
         sel = $urandom_range(0, 3);
         req = NREQ'($urandom_range(1, 15));
         rand_job((sel == 0) ? 2 : ((sel == 3) ? 4 : 3), $urandom_range(0, 3));
         drain();
      end
      req = '0;

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
